// File: rtl/bcd_calc_core.sv
// Four-function-less BCD calculator core: keypad digit entry, digit-serial BCD add/subtract ALU,
// and a multiplexed active-low seven-segment display driver.
module bcd_calc_core #(
  parameter int NDIG    = 4,
  parameter int REFRESH = 50000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [3:0]      entrada,
  input  logic            guardar,
  input  logic            suma,
  input  logic            modo,
  output logic [6:0]      seg,
  output logic [NDIG-1:0] an,
  output logic            busy,
  output logic            ovf,
  output logic            neg
);

  localparam int W  = 4 * NDIG;
  localparam int PW = $clog2(NDIG);
  localparam int CW = $clog2(NDIG + 1);
  localparam int RW = $clog2(REFRESH);

  localparam logic [CW-1:0] CNT_FULL = CW'(NDIG);
  localparam logic [PW-1:0] POS_LAST = PW'(NDIG - 1);
  localparam logic [RW-1:0] RF_LAST  = RW'(REFRESH - 1);

  typedef enum logic [1:0] {S_A, S_B, S_CALC, S_RES} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  cur_q, cur_d;
  logic [W-1:0]  res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pos_q, pos_d;
  logic          pass_q, pass_d;
  logic          carry_q, carry_d;
  logic          cmp_q, cmp_d;
  logic          modo_q, modo_d;
  logic          ovf_q, ovf_d;
  logic          neg_q, neg_d;
  logic [RW-1:0] rfsh_q;
  logic [PW-1:0] idx_q;

  // One BCD digit add with decimal adjust; returns {carry, digit}.
  function automatic logic [4:0] bcd_add(input logic [3:0] x, input logic [3:0] y,
                                         input logic ci);
    logic [4:0] s;
    s = {1'b0, x} + {1'b0, y} + {4'd0, ci};
    if (s > 5'd9) return {1'b1, 4'(s + 5'd6)};
    return {1'b0, s[3:0]};
  endfunction

  function automatic logic [3:0] nines(input logic [3:0] d);
    return 4'd9 - d;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  logic ev_suma, ev_guar, ev_push, dig_ok;
  assign ev_suma = suma;
  assign ev_guar = guardar & ~suma;
  assign ev_push = push & ~suma & ~guardar;
  assign dig_ok  = (entrada <= 4'd9);

  logic [3:0]   ad, bd, rd, xo, yo, sd;
  logic         cout;
  logic [W-1:0] res_w;

  // Pass 1 adds A to B (or to B's nine's complement plus the preset carry);
  // pass 2 either ten's-complements res or copies it through.
  always_comb begin
    ad = 4'd0;
    bd = 4'd0;
    rd = 4'd0;
    for (int k = 0; k < NDIG; k++) begin
      if (pos_q == PW'(k)) begin
        ad = a_q[4*k +: 4];
        bd = b_q[4*k +: 4];
        rd = res_q[4*k +: 4];
      end
    end
    if (!pass_q) begin
      xo = ad;
      yo = modo_q ? nines(bd) : bd;
    end else begin
      xo = cmp_q ? 4'd0 : rd;
      yo = cmp_q ? nines(rd) : 4'd0;
    end
    {cout, sd} = bcd_add(xo, yo, carry_q);
    res_w = res_q;
    for (int k = 0; k < NDIG; k++) begin
      if (pos_q == PW'(k)) res_w[4*k +: 4] = sd;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cur_d   = cur_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    pass_d  = pass_q;
    carry_d = carry_q;
    cmp_d   = cmp_q;
    modo_d  = modo_q;
    ovf_d   = ovf_q;
    neg_d   = neg_q;
    case (state_q)
      S_A: begin
        if (ev_guar) begin
          a_d     = cur_q;
          cur_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          neg_d   = 1'b0;
          state_d = S_B;
        end else if (ev_push && dig_ok && (cnt_q < CNT_FULL)) begin
          cur_d = {cur_q[W-5:0], entrada};
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_B: begin
        if (ev_suma) begin
          modo_d  = modo;
          b_d     = cur_q;
          pos_d   = '0;
          pass_d  = 1'b0;
          carry_d = modo;
          state_d = S_CALC;
        end else if (ev_push && dig_ok && (cnt_q < CNT_FULL)) begin
          cur_d = {cur_q[W-5:0], entrada};
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CALC: begin
        res_d   = res_w;
        carry_d = cout;
        if (pos_q == POS_LAST) begin
          pos_d = '0;
          if (modo_q && !pass_q) begin
            pass_d  = 1'b1;
            cmp_d   = ~cout;
            carry_d = ~cout;
          end else begin
            ovf_d   = modo_q ? 1'b0 : cout;
            neg_d   = modo_q ? cmp_q : 1'b0;
            state_d = S_RES;
          end
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end
      S_RES: begin
        if (ev_guar) begin
          a_d     = res_q;
          cur_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          neg_d   = 1'b0;
          state_d = S_B;
        end else if (ev_push && dig_ok) begin
          cur_d   = {{(W-4){1'b0}}, entrada};
          cnt_d   = CW'(1);
          a_d     = '0;
          ovf_d   = 1'b0;
          neg_d   = 1'b0;
          state_d = S_A;
        end
      end
      default: state_d = S_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      cur_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      pass_q  <= 1'b0;
      carry_q <= 1'b0;
      cmp_q   <= 1'b0;
      modo_q  <= 1'b0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cur_q   <= cur_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      pass_q  <= pass_d;
      carry_q <= carry_d;
      cmp_q   <= cmp_d;
      modo_q  <= modo_d;
      ovf_q   <= ovf_d;
      neg_q   <= neg_d;
    end
  end

  // Display scan: each digit is held for REFRESH cycles, then the scan moves one digit left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rfsh_q <= '0;
      idx_q  <= '0;
    end else if (rfsh_q == RF_LAST) begin
      rfsh_q <= '0;
      idx_q  <= (idx_q == POS_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      rfsh_q <= rfsh_q + 1'b1;
    end
  end

  logic [W-1:0] disp_src;
  logic [3:0]   disp_dig;

  always_comb begin
    disp_src = (state_q == S_RES) ? res_q : cur_q;
    disp_dig = 4'd0;
    for (int k = 0; k < NDIG; k++) begin
      an[k] = (idx_q != PW'(k));
      if (idx_q == PW'(k)) disp_dig = disp_src[4*k +: 4];
    end
  end

  assign seg  = seg7(disp_dig);
  assign busy = (state_q == S_CALC);
  assign ovf  = ovf_q;
  assign neg  = neg_q;

endmodule

// File: tb/tb_bcd_calc_core.sv
// Bench for bcd_calc_core: directed vector table, reset/scan sequences, and random events
// checked against an integer-level calculator model.
module tb_bcd_calc_core;
  localparam int N  = 4;
  localparam int RF = 4;
  localparam int P  = 10000;

  logic         clk = 1'b0;
  logic         rst, push, guardar, suma, modo;
  logic [3:0]   entrada;
  logic [6:0]   seg;
  logic [N-1:0] an;
  logic         busy, ovf, neg;

  always #5 clk = ~clk;

  bcd_calc_core #(.NDIG(N), .REFRESH(RF)) dut (
    .clk(clk), .rst(rst), .push(push), .entrada(entrada), .guardar(guardar),
    .suma(suma), .modo(modo), .seg(seg), .an(an), .busy(busy), .ovf(ovf), .neg(neg)
  );

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    bit p; bit g; bit s; bit m; int e;
    int busy; int disp; int ovf; int neg;
  } vec_t;
  vec_t tbl[$];

  // Model: 0 = entering A, 1 = entering B, 3 = showing result
  int mst, mcur, mcnt, mA, mB, mres, movf, mneg;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int seg2dig(input logic [6:0] s);
    case (s)
      7'b1000000: return 0;
      7'b1111001: return 1;
      7'b0100100: return 2;
      7'b0110000: return 3;
      7'b0011001: return 4;
      7'b0010010: return 5;
      7'b0000010: return 6;
      7'b1111000: return 7;
      7'b0000000: return 8;
      7'b0010000: return 9;
      default:    return -1;
    endcase
  endfunction

  function automatic vec_t v(input bit p, input bit g, input bit s, input bit m, input int e,
                             input int b, input int d, input int o, input int n);
    vec_t r;
    r.p = p; r.g = g; r.s = s; r.m = m; r.e = e;
    r.busy = b; r.disp = d; r.ovf = o; r.neg = n;
    return r;
  endfunction

  task automatic model_reset();
    mst = 0; mcur = 0; mcnt = 0; mA = 0; mB = 0; mres = 0; movf = 0; mneg = 0;
  endtask

  task automatic model_event(input bit p, input bit g, input bit s, input bit m, input int e,
                             output int eb);
    eb = 0;
    if (s) begin
      if (mst == 1) begin
        mB = mcur;
        if (!m) begin
          mres = (mA + mB) % P; movf = ((mA + mB) >= P); mneg = 0; eb = N;
        end else begin
          mres = (mA >= mB) ? mA - mB : mB - mA; mneg = (mA < mB); movf = 0; eb = 2 * N;
        end
        mst = 3;
      end
    end else if (g) begin
      if (mst == 0 || mst == 3) begin
        mA = (mst == 0) ? mcur : mres;
        mcur = 0; mcnt = 0; movf = 0; mneg = 0; mst = 1;
      end
    end else if (p && e <= 9) begin
      if (mst == 3) begin
        mcur = e; mcnt = 1; mA = 0; movf = 0; mneg = 0; mst = 0;
      end else if (mcnt < N) begin
        mcur = mcur * 10 + e; mcnt++;
      end
    end
  endtask

  task automatic drive(input bit p, input bit g, input bit s, input bit m, input int e);
    @(negedge clk);
    push = p; guardar = g; suma = s; modo = m; entrada = 4'(e);
    @(negedge clk);
    push = 0; guardar = 0; suma = 0; modo = 0; entrada = 4'd0;
  endtask

  task automatic read_disp(output int val, output int ok);
    int dig[N];
    int seen, pidx, d;
    seen = 0; ok = 1; val = 0;
    for (int i = 0; i < N; i++) dig[i] = 0;
    for (int k = 0; k < N * RF; k++) begin
      @(negedge clk);
      if ($countones(an) != N - 1) ok = 0;
      pidx = -1;
      for (int i = 0; i < N; i++) if (!an[i]) pidx = i;
      d = seg2dig(seg);
      if (pidx >= 0) begin
        dig[pidx] = d;
        seen = seen | (1 << pidx);
      end
    end
    if (seen != (1 << N) - 1) ok = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (dig[i] < 0) ok = 0;
      val = val * 10 + dig[i];
    end
    if (!ok) val = -1;
  endtask

  task automatic check_event(input string tag, input bit p, input bit g, input bit s,
                             input bit m, input int e, input int eb, input int ed,
                             input int eo, input int en);
    int n, dv, ok;
    drive(p, g, s, m, e);
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, n, eb);
    chk({tag, "_ovf"}, int'(ovf), eo);
    chk({tag, "_neg"}, int'(neg), en);
    read_disp(dv, ok);
    chk({tag, "_scan"}, ok, 1);
    chk({tag, "_display"}, dv, ed);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  initial begin
    int n, eb, e, r;
    bit p, g, s, m;
    rst = 1; push = 0; guardar = 0; suma = 0; modo = 0; entrada = 4'd0;
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_neg", int'(neg), 0);
    chk("rst_an", int'(an), 'b1110);
    chk("rst_seg", int'(seg), 'b1000000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();

    // Digit entry then check the segment pattern on the rightmost digit
    drive(1, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 2);
    drive(1, 0, 0, 0, 3);
    n = 0;
    while (an != 4'b1110 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("entry_idx0_reached", int'(n < 20), 1);
    chk("entry_seg_digit3", int'(seg), 'b0110000);

    do_reset();
    tbl.push_back(v(1,0,0,0, 1, 0,    1, 0, 0));
    tbl.push_back(v(1,0,0,0, 2, 0,   12, 0, 0));
    tbl.push_back(v(1,0,0,0, 3, 0,  123, 0, 0));
    tbl.push_back(v(1,0,0,0, 4, 0, 1234, 0, 0));
    tbl.push_back(v(1,0,0,0, 5, 0, 1234, 0, 0));
    tbl.push_back(v(1,0,0,0,11, 0, 1234, 0, 0));
    tbl.push_back(v(0,1,0,0, 0, 0,    0, 0, 0));
    tbl.push_back(v(1,0,0,0, 5, 0,    5, 0, 0));
    tbl.push_back(v(1,0,0,0, 6, 0,   56, 0, 0));
    tbl.push_back(v(1,0,0,0, 7, 0,  567, 0, 0));
    tbl.push_back(v(1,0,0,0, 8, 0, 5678, 0, 0));
    tbl.push_back(v(0,0,1,0, 0, 4, 6912, 0, 0));
    tbl.push_back(v(1,0,0,0, 0, 0,    0, 0, 0));
    tbl.push_back(v(1,0,0,0, 0, 0,    0, 0, 0));
    tbl.push_back(v(1,0,0,0, 0, 0,    0, 0, 0));
    tbl.push_back(v(1,0,0,0, 5, 0,    5, 0, 0));
    tbl.push_back(v(0,1,0,0, 0, 0,    0, 0, 0));
    tbl.push_back(v(1,0,0,0, 1, 0,    1, 0, 0));
    tbl.push_back(v(1,0,0,0, 2, 0,   12, 0, 0));
    tbl.push_back(v(0,1,1,1, 0, 8,    7, 0, 1));
    tbl.push_back(v(0,1,0,0, 0, 0,    0, 0, 0));
    tbl.push_back(v(1,0,0,0, 9, 0,    9, 0, 0));
    tbl.push_back(v(0,0,1,0, 0, 4,   16, 0, 0));
    tbl.push_back(v(1,0,0,0, 9, 0,    9, 0, 0));
    tbl.push_back(v(1,0,0,0, 9, 0,   99, 0, 0));
    tbl.push_back(v(1,0,0,0, 9, 0,  999, 0, 0));
    tbl.push_back(v(1,0,0,0, 9, 0, 9999, 0, 0));
    tbl.push_back(v(0,1,0,0, 0, 0,    0, 0, 0));
    tbl.push_back(v(1,0,0,0, 1, 0,    1, 0, 0));
    tbl.push_back(v(0,0,1,0, 0, 4,    0, 1, 0));
    tbl.push_back(v(1,0,0,0, 3, 0,    3, 0, 0));
    tbl.push_back(v(0,0,1,0, 0, 0,    3, 0, 0));
    tbl.push_back(v(1,1,0,0, 7, 0,    0, 0, 0));
    tbl.push_back(v(1,0,0,0, 8, 0,    8, 0, 0));
    tbl.push_back(v(0,0,1,1, 0, 8,    5, 0, 1));
    for (int i = 0; i < tbl.size(); i++)
      check_event($sformatf("vec%0d", i), tbl[i].p, tbl[i].g, tbl[i].s, tbl[i].m, tbl[i].e,
                  tbl[i].busy, tbl[i].disp, tbl[i].ovf, tbl[i].neg);

    // Reset in the second cycle of an addition
    do_reset();
    drive(1, 0, 0, 0, 4);
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 6);
    drive(0, 0, 1, 0, 0);
    chk("midrst_busy_c1", int'(busy), 1);
    @(negedge clk);
    #1 rst = 1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ovf", int'(ovf), 0);
    chk("midrst_neg", int'(neg), 0);
    chk("midrst_an", int'(an), 'b1110);
    chk("midrst_seg", int'(seg), 'b1000000);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("scan_an_%0d", k), int'(an), int'(4'b1111 & ~(4'b0001 << ((k / 4) % 4))));
      @(negedge clk);
    end
    check_event("post_rst_push", 1, 0, 0, 0, 7, 0, 7, 0, 0);
    mcur = 7; mcnt = 1;

    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 9);
      p = 0; g = 0; s = 0; m = 0; e = 0;
      if (r <= 5) begin
        p = 1; e = $urandom_range(0, 11);
      end else if (r <= 7) begin
        g = 1;
      end else begin
        s = 1; m = 1'($urandom_range(0, 1));
      end
      model_event(p, g, s, m, e, eb);
      check_event($sformatf("rnd%0d", i), p, g, s, m, e, eb,
                  (mst == 3) ? mres : mcur, movf, mneg);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
